// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiplier (radix-2 Booth) / divider (non-restoring) with start/busy/done handshake.
// Define MULDIV_DIV_EN to build the divider datapath; without it op=1 only times out and returns zero.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]           cnt;
  logic                    op_q;
  logic                    accept;
  // acc carries two guard bits: Booth needs WIDTH+1, the divider's shifted remainder WIDTH+2
  logic signed [WIDTH+1:0] acc, m;
  logic [WIDTH-1:0]        q;
  logic                    q_1;
  logic signed [WIDTH+1:0] booth_sum;
  logic [2*WIDTH-1:0]      fix;

`ifdef MULDIV_DIV_EN
  logic                    neg_q, sa_q, dz_q;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        a_mag, b_mag, rem_mag, rem_s, quo_s;
  logic signed [WIDTH+1:0] shl, div_sum;

  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;
  assign shl     = {acc[WIDTH:0], q[WIDTH-1]};
  assign div_sum = acc[WIDTH+1] ? shl + m : shl - m;
  assign rem_mag = acc[WIDTH+1] ? acc[WIDTH-1:0] + m[WIDTH-1:0] : acc[WIDTH-1:0];
  assign quo_s   = neg_q ? -q : q;
  assign rem_s   = sa_q ? -rem_mag : rem_mag;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == MUL) || (state == DIV) || (state == FIXUP);
  assign done   = (state == DONE);

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
  end

  always_comb begin
    fix = {acc[WIDTH-1:0], q};
    if (op_q) begin
`ifdef MULDIV_DIV_EN
      fix = dz_q ? {a_q, {WIDTH{1'b1}}} : {rem_s, quo_s};
`else
      fix = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (op ? DIV : MUL) : IDLE;
      MUL, DIV:   if (cnt == '0) state_nxt = FIXUP;
      FIXUP:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      op_q        <= 1'b0;
      acc         <= '0;
      m           <= '0;
      q           <= '0;
      q_1         <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_q       <= 1'b0;
      sa_q        <= 1'b0;
      dz_q        <= 1'b0;
      a_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (accept) begin
          cnt         <= CW'(WIDTH);
          op_q        <= op;
          acc         <= '0;
          q_1         <= 1'b0;
          div_by_zero <= 1'b0;
          m           <= {{2{a[WIDTH-1]}}, a};
          q           <= b;
`ifdef MULDIV_DIV_EN
          a_q   <= a;
          neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          sa_q  <= a[WIDTH-1];
          dz_q  <= op && (b == '0);
          if (op) begin
            m <= {2'b00, b_mag};
            q <= a_mag;
          end
`endif
        end
        MUL: if (cnt != '0) begin
          acc <= booth_sum >>> 1;
          q   <= {booth_sum[0], q[WIDTH-1:1]};
          q_1 <= q[0];
          cnt <= cnt - 1'b1;
        end
        DIV: if (cnt != '0) begin
`ifdef MULDIV_DIV_EN
          acc <= div_sum;
          q   <= {q[WIDTH-2:0], ~div_sum[WIDTH+1]};
`endif
          cnt <= cnt - 1'b1;
        end
        FIXUP: begin
          result <= fix;
`ifdef MULDIV_DIV_EN
          div_by_zero <= op_q && dz_q;
`else
          div_by_zero <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: random stimulus against a latency/arithmetic model, plus fixed literal cases.
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic          clk, clr, start, op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [2*W-1:0] result;

  int checks = 0, failures = 0;
  bit cmp_en = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(input bit o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) return 64'(sx * sy);
    if (!DIV_ON) return 64'd0;
    if (y == 0) return {x, 32'hFFFF_FFFF};
    qq = sx / sy;
    rr = sx % sy;
    return {32'(rr), 32'(qq)};
  endfunction

  // Model: an accepted request becomes visible LAT edges later; nothing else is accepted meanwhile.
  bit          m_busy, m_done, m_dbz, m_pdbz;
  int          m_left;
  logic [63:0] m_res, m_pending;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_res = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_res = m_pending; m_dbz = m_pdbz;
        end
      end else if (start) begin
        m_busy    = 1;
        m_left    = LAT;
        m_dbz     = 0;
        m_pending = ref_res(op, a, b);
        m_pdbz    = DIV_ON && op && (b == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !clr) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_result", result, m_res);
      chk("cyc_dbz", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  // b2b=1: caller is already in a done cycle, so present the request right away.
  task automatic do_op(input bit b2b, input bit o, input logic [31:0] x, input logic [31:0] y,
                       output logic [63:0] r, output bit z, output int lat);
    if (!b2b) begin @(posedge clk); #1; end
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result; z = div_by_zero;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      6: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    bit z;
    int lat;
    clr = 1; start = 0; op = 0; a = '0; b = '0;
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_dbz", 64'(div_by_zero), 0);
    clr = 0;
    cmp_en = 1;

    do_op(0, 0, 32'd7, 32'hFFFF_FFFD, r, z, lat);
    chk("mul_7_m3", r, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("lat_mul", 64'(lat), 64'(LAT));
    do_op(0, 0, 32'h8000_0000, 32'h8000_0000, r, z, lat);
    chk("mul_minmin", r, 64'h4000_0000_0000_0000);
    do_op(0, 1, -32'd17, 32'd5, r, z, lat);
    chk("div_m17_5", r, DIV_ON ? 64'hFFFF_FFFE_FFFF_FFFD : 64'd0);
    chk("lat_div", 64'(lat), 64'(LAT));
    do_op(0, 1, 32'd17, -32'd5, r, z, lat);
    chk("div_17_m5", r, DIV_ON ? 64'h0000_0002_FFFF_FFFD : 64'd0);
    do_op(0, 1, 32'd9, 32'd0, r, z, lat);
    chk("div_by0_res", r, DIV_ON ? 64'h0000_0009_FFFF_FFFF : 64'd0);
    chk("div_by0_flag", 64'(z), 64'(DIV_ON));
    chk("lat_div0", 64'(lat), 64'(LAT));
    do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, r, z, lat);
    chk("div_ovf", r, DIV_ON ? 64'h0000_0000_8000_0000 : 64'd0);
    chk("div_ovf_flag", 64'(z), 0);

    // Abandoned multiply: a second start mid-flight is ignored, then clr discards everything.
    @(posedge clk); #1; start = 1; op = 0; a = 32'd123; b = 32'd456;
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    #1; start = 1; op = 1; a = 32'd5; b = 32'd0;
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    #3; clr = 1;
    #1;
    chk("clr_busy", 64'(busy), 0);
    chk("clr_done", 64'(done), 0);
    chk("clr_result", result, 0);
    chk("clr_dbz", 64'(div_by_zero), 0);
    clr = 0;

    do_op(0, 0, 32'd6, 32'd7, r, z, lat);
    chk("mul_6_7", r, 64'd42);
    chk("lat_6_7", 64'(lat), 64'(LAT));
    do_op(1, 1, 32'd100, 32'd7, r, z, lat);
    chk("b2b_div", r, DIV_ON ? {32'd2, 32'd14} : 64'd0);
    chk("b2b_lat", 64'(lat), 64'(LAT));

    repeat (2500) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      op    = 1'($urandom_range(0, 1));
      a     = pick();
      b     = pick();
    end
    start = 0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
